debug_send: RTL and testbench

DEBUG_SEND -- requirements
Module: debug_send

---
 rtl/debug_send.sv | 174 +++++++++++++++++
 tb/tb_debug_send.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_send.sv
// Debug state dumper: streams PC, step count, register file and data memory out over the UART, bytewise LSB first.
// Optional build macro DEBUG_SEND_CHECKSUM_EN appends a running-XOR checksum byte to the frame.
module debug_send #(
  parameter int unsigned N_REGS = 32,
  parameter int unsigned N_MEM  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start_send,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_clk_count,
  output logic [4:0]  o_reg_addr,
  input  logic [31:0] i_reg_data,
  output logic [4:0]  o_mem_addr,
  input  logic [31:0] i_mem_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic        o_done_send,
  output logic        o_busy
);

  localparam int unsigned IDX_W    = 7;
  localparam int unsigned REG_BASE = 2;
  localparam int unsigned MEM_BASE = REG_BASE + N_REGS;
  localparam int unsigned N_WORDS  = MEM_BASE + N_MEM;
`ifdef DEBUG_SEND_CHECKSUM_EN
  // The checksum travels as a pseudo-word at index N_WORDS carrying a single byte.
  localparam int unsigned LAST_IDX = N_WORDS;
`else
  localparam int unsigned LAST_IDX = N_WORDS - 1;
`endif

  typedef enum logic [2:0] {
    IDLE, SET_ADDR, LATCH, SEND, WAIT_TX, NEXT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_q, byte_d;
  logic [31:0]        shift_q, shift_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [4:0]         reg_addr_d, mem_addr_d;
  logic [7:0]         tx_data_d;
  logic               tx_start_d, done_send_d, busy_d;
`ifdef DEBUG_SEND_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      o_reg_addr  <= '0;
      o_mem_addr  <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_done_send <= 1'b0;
      o_busy      <= 1'b0;
`ifdef DEBUG_SEND_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      shift_q     <= shift_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      o_reg_addr  <= reg_addr_d;
      o_mem_addr  <= mem_addr_d;
      o_tx_data   <= tx_data_d;
      o_tx_start  <= tx_start_d;
      o_done_send <= done_send_d;
      o_busy      <= busy_d;
`ifdef DEBUG_SEND_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    reg_addr_d = o_reg_addr;
    mem_addr_d = o_mem_addr;
    tx_data_d  = o_tx_data;
`ifdef DEBUG_SEND_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start_send) begin
          pc_d    = i_pc;
          cnt_d   = i_clk_count;
          idx_d   = '0;
`ifdef DEBUG_SEND_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = SET_ADDR;
        end
      end
      SET_ADDR: state_d = LATCH;
      LATCH: begin
        byte_d = '0;
        if (idx_q == IDX_W'(0))             shift_d = pc_q;
        else if (idx_q == IDX_W'(1))        shift_d = cnt_q;
        else if (idx_q < IDX_W'(MEM_BASE))  shift_d = i_reg_data;
        else if (idx_q < IDX_W'(N_WORDS))   shift_d = i_mem_data;
`ifdef DEBUG_SEND_CHECKSUM_EN
        else begin
          shift_d = {24'h0, chk_q};
          byte_d  = 2'd3;
        end
`endif
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_q == 2'd3) begin
            state_d = NEXT;
          end else begin
            shift_d = shift_q >> 8;
            byte_d  = 2'(byte_q + 2'd1);
            state_d = SEND;
          end
        end
      end
      NEXT: begin
        if (idx_q == IDX_W'(LAST_IDX)) begin
          state_d = DONE;
        end else begin
          idx_d   = IDX_W'(idx_q + IDX_W'(1));
          state_d = SET_ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Debug read addresses change only on entry to SET_ADDR, otherwise they hold.
    if (state_d == SET_ADDR) begin
      if (idx_d >= IDX_W'(REG_BASE) && idx_d < IDX_W'(MEM_BASE))
        reg_addr_d = 5'(idx_d - IDX_W'(REG_BASE));
      else if (idx_d >= IDX_W'(MEM_BASE) && idx_d < IDX_W'(N_WORDS))
        mem_addr_d = 5'(idx_d - IDX_W'(MEM_BASE));
    end

    if (state_d == SEND) begin
      tx_data_d = shift_d[7:0];
`ifdef DEBUG_SEND_CHECKSUM_EN
      if (idx_d != IDX_W'(N_WORDS))
        chk_d = chk_q ^ shift_d[7:0];
`endif
    end

    tx_start_d  = (state_d == SEND);
    done_send_d = (state_d == DONE);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
  end

endmodule

// File: tb/tb_debug_send.sv
// Scoreboard bench for debug_send: expected frame bytes queued at request time, popped on each o_tx_start.
// Build with DEBUG_SEND_CHECKSUM_EN to also exercise the checksum byte.
module tb_debug_send;

  localparam int unsigned N_REGS = 32;
  localparam int unsigned N_MEM  = 32;
`ifdef DEBUG_SEND_CHECKSUM_EN
  localparam int FRAME_LEN = 8 + 4 * (N_REGS + N_MEM) + 1;
`else
  localparam int FRAME_LEN = 8 + 4 * (N_REGS + N_MEM);
`endif
  localparam int TIMEOUT = 8000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start_send = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_clk_count = '0;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data = '0;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_data = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_done_send;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  logic [7:0] last_byte = '0;
  int bytes_sent = 0;
  int done_cnt = 0;
  int ucnt = 0;
  logic uart_done = 1'b0;
  logic spur = 1'b0;
  logic spur_en = 1'b0;
  logic zero_mode = 1'b0;

  assign i_tx_done = uart_done | spur;

  always #5 clk = ~clk;

  debug_send #(.N_REGS(N_REGS), .N_MEM(N_MEM)) dut (
    .clk(clk), .rst(rst), .i_start_send(i_start_send), .i_pc(i_pc),
    .i_clk_count(i_clk_count), .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .o_done_send(o_done_send),
    .o_busy(o_busy)
  );

  // Synchronous-read memories and a UART that finishes 10 cycles after each start.
  always @(posedge clk) begin
    i_reg_data <= zero_mode ? 32'h0 : 32'(o_reg_addr);
    i_mem_data <= zero_mode ? 32'h0 : 32'hA500_0000 + 32'(o_mem_addr);
    uart_done  <= 1'b0;
    if (!rst) ucnt <= 0;
    else if (o_tx_start) ucnt <= 10;
    else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) uart_done <= 1'b1;
    end
  end

  // Monitor: score every launched byte; inject done pulses whenever the DUT is not waiting on the UART.
  always @(negedge clk) begin
    spur <= spur_en && o_busy && (ucnt == 0) && !uart_done;
    if (o_done_send) done_cnt++;
    if (o_tx_start) begin
      bytes_sent++;
      last_byte = o_tx_data;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tx_byte[%0d]: got %02h, expected no byte", bytes_sent, o_tx_data);
      end else begin
        exp_b = sb.pop_front();
        if (o_tx_data !== exp_b) begin
          errors++;
          $display("FAIL tx_byte[%0d]: got %02h, expected %02h", bytes_sent, o_tx_data, exp_b);
        end
      end
    end
  end

  task automatic push_frame(input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] w;
    logic [7:0]  x;
    x = 8'h00;
    for (int k = 0; k < int'(2 + N_REGS + N_MEM); k++) begin
      if (k == 0)                 w = pc;
      else if (k == 1)            w = cnt;
      else if (k < int'(2 + N_REGS)) w = zero_mode ? 32'h0 : 32'(k - 2);
      else                        w = zero_mode ? 32'h0 : 32'hA500_0000 + 32'(k - 2 - int'(N_REGS));
      for (int b = 0; b < 4; b++) begin
        sb.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef DEBUG_SEND_CHECKSUM_EN
    sb.push_back(x);
`endif
  endtask

  task automatic start_frame(input logic [31:0] pc, input logic [31:0] cnt);
    i_pc = pc;
    i_clk_count = cnt;
    @(posedge clk); #1 i_start_send = 1'b1;
    @(posedge clk); #1 i_start_send = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk); #1;
      if (bytes_sent >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (o_tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data: got %02h, expected 00", o_tx_data); end
    if (o_tx_start !== 1'b0)  begin errors++; $display("FAIL reset_tx_start: got %b, expected 0", o_tx_start); end
    if (o_done_send !== 1'b0) begin errors++; $display("FAIL reset_done_send: got %b, expected 0", o_done_send); end
    if (o_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
    if (o_reg_addr !== 5'd0)  begin errors++; $display("FAIL reset_reg_addr: got %0d, expected 0", o_reg_addr); end
    if (o_mem_addr !== 5'd0)  begin errors++; $display("FAIL reset_mem_addr: got %0d, expected 0", o_mem_addr); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame();
    int d0, b0;
    bit ok;
    d0 = done_cnt; b0 = bytes_sent;
    push_frame(32'h0000_0010, 32'd3);
    start_frame(32'h0000_0010, 32'd3);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_start: got %b, expected 1", o_busy); end
    wait_done(d0, ok);
    repeat (5) @(posedge clk);
    #1;
    checks += 5;
    if (!ok) begin errors++; $display("FAIL frame_timeout: got no done, expected done within %0d cycles", TIMEOUT); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL frame_done_pulses: got %0d, expected 1", done_cnt - d0); end
    if (bytes_sent - b0 != FRAME_LEN) begin errors++; $display("FAIL frame_len: got %0d, expected %0d", bytes_sent - b0, FRAME_LEN); end
    if (sb.size() != 0) begin errors++; $display("FAIL frame_leftover: got %0d unsent, expected 0", sb.size()); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b, expected 0", o_busy); end
    sb.delete();
  endtask

  task automatic test_restart();
    int d0, b0;
    bit ok, ok2;
    d0 = done_cnt; b0 = bytes_sent;
    push_frame(32'h1234_5678, 32'd99);
    start_frame(32'h1234_5678, 32'd99);
    wait_bytes(b0 + 5, ok);
    start_frame(32'hDEAD_BEEF, 32'd7);
    wait_done(d0, ok2);
    repeat (5) @(posedge clk);
    #1;
    checks += 4;
    if (!(ok && ok2)) begin errors++; $display("FAIL restart_timeout: got no done, expected done within %0d cycles", TIMEOUT); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done_pulses: got %0d, expected 1", done_cnt - d0); end
    if (bytes_sent - b0 != FRAME_LEN) begin errors++; $display("FAIL restart_len: got %0d, expected %0d", bytes_sent - b0, FRAME_LEN); end
    if (sb.size() != 0) begin errors++; $display("FAIL restart_leftover: got %0d unsent, expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_spurious();
    int d0, b0;
    bit ok;
    d0 = done_cnt; b0 = bytes_sent;
    spur_en = 1'b1;
    push_frame(32'hCAFE_0001, 32'h0001_0000);
    start_frame(32'hCAFE_0001, 32'h0001_0000);
    wait_done(d0, ok);
    spur_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL spurious_timeout: got no done, expected done within %0d cycles", TIMEOUT); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL spurious_done_pulses: got %0d, expected 1", done_cnt - d0); end
    if (bytes_sent - b0 != FRAME_LEN) begin errors++; $display("FAIL spurious_len: got %0d, expected %0d", bytes_sent - b0, FRAME_LEN); end
    if (sb.size() != 0) begin errors++; $display("FAIL spurious_leftover: got %0d unsent, expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_abort();
    int d0, b0;
    bit ok;
    d0 = done_cnt; b0 = bytes_sent;
    push_frame(32'h0BAD_F00D, 32'd42);
    start_frame(32'h0BAD_F00D, 32'd42);
    wait_bytes(b0 + 100, ok);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks += 8;
    if (!ok) begin errors++; $display("FAIL abort_timeout: got %0d bytes, expected 100", bytes_sent - b0); end
    if (o_tx_data !== 8'h00)  begin errors++; $display("FAIL abort_tx_data: got %02h, expected 00", o_tx_data); end
    if (o_tx_start !== 1'b0)  begin errors++; $display("FAIL abort_tx_start: got %b, expected 0", o_tx_start); end
    if (o_done_send !== 1'b0) begin errors++; $display("FAIL abort_done_send: got %b, expected 0", o_done_send); end
    if (o_busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b, expected 0", o_busy); end
    if (o_reg_addr !== 5'd0)  begin errors++; $display("FAIL abort_reg_addr: got %0d, expected 0", o_reg_addr); end
    if (o_mem_addr !== 5'd0)  begin errors++; $display("FAIL abort_mem_addr: got %0d, expected 0", o_mem_addr); end
    rst = 1'b1;
    sb.delete();
    repeat (20) @(posedge clk);
    #1;
    if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses, expected 0", done_cnt - d0); end
    test_frame();
  endtask

`ifdef DEBUG_SEND_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    bit ok;
    d0 = done_cnt;
    zero_mode = 1'b1;
    push_frame(32'h0102_0304, 32'd0);
    start_frame(32'h0102_0304, 32'd0);
    wait_done(d0, ok);
    zero_mode = 1'b0;
    checks += 3;
    if (!ok) begin errors++; $display("FAIL checksum_timeout: got no done, expected done within %0d cycles", TIMEOUT); end
    if (last_byte !== 8'h04) begin errors++; $display("FAIL checksum_byte: got %02h, expected 04", last_byte); end
    if (sb.size() != 0) begin errors++; $display("FAIL checksum_leftover: got %0d unsent, expected 0", sb.size()); end
    sb.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_restart();
    test_spurious();
    test_reset_abort();
`ifdef DEBUG_SEND_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
